fuel_pump_scheduler: RTL and testbench

Shares one metered pump and litre/cost datapath among N_NOZZLE dispenser nozzles.
- Grants nozzles round-robin and latches each nozzle's fuel type and target litres.
- Runs the pump until the target is reached or the nozzle hangs up, accumulating litres and cost.
- Publishes a one-cycle completion record for the receipt/print stage.

---
 rtl/fuel_pump_scheduler_pkg.sv | 41 ++++
 rtl/fuel_pump_scheduler_rr_arbiter.sv | 30 +++
 rtl/fuel_pump_scheduler.sv | 163 ++++++++++++++++
 tb/tb_fuel_pump_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fuel_pump_scheduler_pkg.sv
// Shared definitions for the fuel pump scheduler: fuel codes, FSM states and
// the fuel-code to unit-price mapping.
package fuel_pkg;

    typedef enum logic [1:0] {
        FUEL_NONE = 2'b00,
        FUEL_LPG  = 2'b01,
        FUEL_PB   = 2'b10,
        FUEL_ON   = 2'b11
    } fuel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        FUEL   = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int PRICE_W       = 4;
    localparam int DEF_PRICE_LPG = 3;
    localparam int DEF_PRICE_PB  = 6;
    localparam int DEF_PRICE_ON  = 7;

    function automatic logic [PRICE_W-1:0] price_lookup(
        input logic [1:0]         code,
        input logic [PRICE_W-1:0] p_lpg,
        input logic [PRICE_W-1:0] p_pb,
        input logic [PRICE_W-1:0] p_on
    );
        logic [PRICE_W-1:0] p;
        p = '0;
        case (code)
            FUEL_LPG: p = p_lpg;
            FUEL_PB:  p = p_pb;
            FUEL_ON:  p = p_on;
            default:  p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/fuel_pump_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] eligible,
    input  logic [2:0]   ptr,
    output logic         any_vld,
    output logic [2:0]   grant
);

    function automatic int wrap_idx(input int p, input int k);
        int s;
        s = p + k;
        return (s >= N) ? s - N : s;
    endfunction

    // Scan from the farthest offset down so the closest eligible index wins.
    always_comb begin
        any_vld = 1'b0;
        grant   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (eligible[wrap_idx(int'(ptr), k)]) begin
                any_vld = 1'b1;
                grant   = 3'(wrap_idx(int'(ptr), k));
            end
        end
    end

endmodule

// File: rtl/fuel_pump_scheduler.sv
// Shares one metered pump among N_NOZZLE nozzles: round-robin grant, litre/cost
// accumulation, and a one-cycle completion record per transaction.
import fuel_pkg::*;

module fuel_pump_scheduler #(
    parameter int N_NOZZLE  = 4,
    parameter int LW        = 8,
    parameter int CW        = 12,
    parameter int PRICE_LPG = DEF_PRICE_LPG,
    parameter int PRICE_PB  = DEF_PRICE_PB,
    parameter int PRICE_ON  = DEF_PRICE_ON
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_NOZZLE-1:0]    req,
    input  logic [2*N_NOZZLE-1:0]  fuel,
    input  logic [LW*N_NOZZLE-1:0] target,
    input  logic                   pump_tick,
    output logic                   pump_en,
    output logic                   grant_vld,
    output logic [2:0]             grant_id,
    output logic [LW-1:0]          litres,
    output logic [CW-1:0]          cost,
    output logic                   done,
    output logic [2:0]             done_id,
    output logic [LW-1:0]          done_litres,
    output logic [CW-1:0]          done_cost,
    output logic                   done_err,
    output logic                   done_abort
);

    state_t state, state_nxt;

    logic [N_NOZZLE-1:0] served, eligible, report_mask;
    logic [2:0]          rr_ptr, arb_idx, gid;
    logic                arb_vld;
    logic [1:0]          sel_fuel, fuel_q;
    logic [LW-1:0]       sel_target, target_q;
    logic [LW-1:0]       litres_q, litres_nxt;
    logic [CW-1:0]       cost_q, cost_nxt;
    logic [PRICE_W-1:0]  price_q;
    logic                req_g, hit, rpt_err, rpt_abort;

    assign eligible   = req & ~served;
    assign sel_fuel   = fuel[2*arb_idx +: 2];
    assign sel_target = target[LW*arb_idx +: LW];
    assign req_g      = req[gid];

    assign grant_id = gid;
    assign litres   = litres_q;
    assign cost     = cost_q;

    rr_arbiter #(.N(N_NOZZLE)) u_arb (
        .eligible (eligible),
        .ptr      (rr_ptr),
        .any_vld  (arb_vld),
        .grant    (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pump_en     = 1'b0;
        done        = 1'b0;
        grant_vld   = (state != IDLE);
        hit         = 1'b0;
        rpt_err     = 1'b0;
        rpt_abort   = 1'b0;
        litres_nxt  = litres_q;
        cost_nxt    = cost_q;
        report_mask = '0;
        case (state)
            IDLE: begin
                if (arb_vld) state_nxt = SELECT;
            end
            SELECT: begin
                if (fuel_q == FUEL_NONE || target_q == '0) begin
                    state_nxt = REPORT;
                    rpt_err   = 1'b1;
                end else begin
                    state_nxt = FUEL;
                end
            end
            FUEL: begin
                pump_en = 1'b1;
                if (pump_tick) begin
                    litres_nxt = litres_q + LW'(1);
                    cost_nxt   = cost_q + CW'(price_q);
                end
                // A tick that reaches the target completes normally even if req drops with it.
                hit = pump_tick && (litres_nxt == target_q);
                if (hit) begin
                    state_nxt = REPORT;
                end else if (!req_g) begin
                    state_nxt = REPORT;
                    rpt_abort = 1'b1;
                end
            end
            REPORT: begin
                done        = 1'b1;
                report_mask = N_NOZZLE'(1) << gid;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            served      <= '0;
            rr_ptr      <= '0;
            gid         <= '0;
            fuel_q      <= '0;
            target_q    <= '0;
            price_q     <= '0;
            litres_q    <= '0;
            cost_q      <= '0;
            done_id     <= '0;
            done_litres <= '0;
            done_cost   <= '0;
            done_err    <= 1'b0;
            done_abort  <= 1'b0;
        end else begin
            // A dropped req always clears the served bit, even on the REPORT cycle.
            served <= (served | report_mask) & req;
            case (state)
                IDLE: begin
                    if (arb_vld) begin
                        gid      <= arb_idx;
                        fuel_q   <= sel_fuel;
                        target_q <= sel_target;
                        price_q  <= price_lookup(sel_fuel, PRICE_W'(PRICE_LPG),
                                                 PRICE_W'(PRICE_PB), PRICE_W'(PRICE_ON));
                        litres_q <= '0;
                        cost_q   <= '0;
                    end
                end
                FUEL: begin
                    litres_q <= litres_nxt;
                    cost_q   <= cost_nxt;
                end
                REPORT: begin
                    litres_q <= '0;
                    cost_q   <= '0;
                    rr_ptr   <= (gid == 3'(N_NOZZLE - 1)) ? 3'd0 : gid + 3'd1;
                end
                default: ;
            endcase
            if (state_nxt == REPORT) begin
                done_id     <= gid;
                done_litres <= litres_nxt;
                done_cost   <= cost_nxt;
                done_err    <= rpt_err;
                done_abort  <= rpt_abort;
            end
        end
    end

endmodule

// File: tb/tb_fuel_pump_scheduler.sv
// Directed and randomized bench for fuel_pump_scheduler with a transaction-level
// reference model (price table, min(target,ticks) litres, round-robin winner).
module tb_fuel_pump_scheduler;

    localparam int N  = 4;
    localparam int LW = 8;
    localparam int CW = 12;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [2*N-1:0]  fuel;
    logic [LW*N-1:0] target;
    logic            pump_tick;
    logic            pump_en, grant_vld, done, done_err, done_abort;
    logic [2:0]      grant_id, done_id;
    logic [LW-1:0]   litres, done_litres;
    logic [CW-1:0]   cost, done_cost;

    int n_cmp = 0;
    int n_err = 0;
    int m_ptr = 0;

    fuel_pump_scheduler #(.N_NOZZLE(N), .LW(LW), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .fuel        (fuel),
        .target      (target),
        .pump_tick   (pump_tick),
        .pump_en     (pump_en),
        .grant_vld   (grant_vld),
        .grant_id    (grant_id),
        .litres      (litres),
        .cost        (cost),
        .done        (done),
        .done_id     (done_id),
        .done_litres (done_litres),
        .done_cost   (done_cost),
        .done_err    (done_err),
        .done_abort  (done_abort)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_price(input int f);
        case (f)
            1:       return 3;
            2:       return 6;
            3:       return 7;
            default: return 0;
        endcase
    endfunction

    function automatic int model_winner(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++)
            if (mask[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic noise(input int id);
        for (int n = 0; n < N; n++)
            if (n != id) begin
                fuel[n*2 +: 2]    = 2'($urandom);
                target[n*LW +: LW] = 8'($urandom);
            end
    endtask

    // One full transaction on nozzle id; drop_after<0 means req is held to the end.
    task automatic do_txn(input int id, input int f, input int t, input int drop_after,
                          input int mode, input int gap, input bit hold);
        int  price, delivered;
        bit  err, abort, fin;
        price     = model_price(f);
        err       = (f == 0) || (t == 0);
        delivered = 0;
        abort     = 1'b0;
        fuel[id*2 +: 2]     = 2'(f);
        target[id*LW +: LW] = 8'(t);
        req[id]   = 1'b1;
        pump_tick = 1'($urandom_range(0, 1));
        cyc();
        pump_tick = 1'($urandom_range(0, 1));
        chk("sel_vld", grant_vld, 1);
        chk("sel_id", grant_id, id);
        chk("sel_pump", pump_en, 0);
        chk("sel_done", done, 0);
        cyc();
        pump_tick = 1'b0;
        if (!err) begin
            chk("fuel_pump", pump_en, 1);
            chk("fuel_litres0", litres, 0);
            fin = 1'b0;
            while (!fin) begin
                if (drop_after >= 0 && delivered == drop_after) begin
                    req[id]   = 1'b0;
                    pump_tick = 1'(mode);
                    cyc();
                    pump_tick = 1'b0;
                    delivered += mode;
                    abort = (delivered != t);
                    fin   = 1'b1;
                end else begin
                    noise(id);
                    pump_tick = 1'b1;
                    cyc();
                    pump_tick = 1'b0;
                    delivered++;
                    if (delivered == t) begin
                        fin = 1'b1;
                    end else begin
                        chk("run_litres", litres, delivered);
                        chk("run_cost", cost, delivered * price);
                        for (int g = 0; g < gap; g++) begin
                            cyc();
                            chk("gap_pump", pump_en, 1);
                        end
                    end
                end
            end
        end
        chk("rpt_done", done, 1);
        chk("rpt_vld", grant_vld, 1);
        chk("rpt_pump", pump_en, 0);
        chk("rpt_id", done_id, id);
        chk("rpt_litres", done_litres, delivered);
        chk("rpt_cost", done_cost, delivered * price);
        chk("rpt_err", done_err, err);
        chk("rpt_abort", done_abort, abort);
        cyc();
        chk("idle_done", done, 0);
        chk("idle_vld", grant_vld, 0);
        chk("idle_litres", litres, 0);
        chk("idle_cost", cost, 0);
        chk("idle_hold_litres", done_litres, delivered);
        m_ptr = (id + 1) % N;
        if (!hold) req[id] = 1'b0;
    endtask

    initial begin
        logic [N-1:0] mask;
        int w, f, t, d;
        reset = 1'b1; req = '0; fuel = '0; target = '0; pump_tick = 1'b0;
        cyc(); cyc();
        chk("rst_pump", pump_en, 0);
        chk("rst_vld", grant_vld, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_litres", litres, 0);
        chk("rst_cost", cost, 0);
        chk("rst_done", done, 0);
        chk("rst_did", done_id, 0);
        chk("rst_dlit", done_litres, 0);
        chk("rst_dcost", done_cost, 0);
        chk("rst_derr", done_err, 0);
        chk("rst_dabort", done_abort, 0);
        reset = 1'b0;
        cyc();

        // Diesel, 22 litres, ticks every 3 cycles.
        do_txn(0, 3, 22, -1, 0, 2, 0);
        chk("t1_cost154", done_cost, 154);

        // Nozzles 1 and 2 together from pointer 1 -> 1 first, then 2.
        req[2] = 1'b1;
        do_txn(1, 2, 5, -1, 0, 0, 0);
        chk("t2_cost30", done_cost, 30);
        do_txn(2, 1, 4, -1, 0, 1, 0);

        // Pointer at 3: nozzle 3 beats nozzle 0; invalid fuel code.
        fuel[1:0] = 2'b01; target[7:0] = 8'd31; req[0] = 1'b1;
        do_txn(3, 0, 10, -1, 0, 0, 0);
        // LPG, hang up after 5 ticks.
        do_txn(0, 1, 31, 5, 0, 1, 0);
        chk("t4_cost15", done_cost, 15);

        // Reset in the middle of FUEL.
        fuel[1:0] = 2'b10; target[7:0] = 8'd20; req[0] = 1'b1;
        cyc(); cyc();
        for (int i = 0; i < 7; i++) begin
            pump_tick = 1'b1; cyc(); pump_tick = 1'b0;
        end
        chk("t5_litres7", litres, 7);
        chk("t5_cost42", cost, 42);
        req[1] = 1'b1;
        reset  = 1'b1;
        cyc();
        reset  = 1'b0;
        m_ptr  = 0;
        chk("t5_pump", pump_en, 0);
        chk("t5_vld", grant_vld, 0);
        chk("t5_litres", litres, 0);
        chk("t5_done", done, 0);
        chk("t5_dlit", done_litres, 0);
        chk("t5_dabort", done_abort, 0);
        do_txn(0, 2, 20, -1, 0, 0, 0);
        do_txn(1, 3, 3, -1, 0, 0, 0);

        // Held req after completion must not re-grant; ticks in IDLE ignored.
        do_txn(2, 3, 4, -1, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            pump_tick = 1'b1;
            cyc();
            chk("t6_vld", grant_vld, 0);
            chk("t6_litres", litres, 0);
            chk("t6_pump", pump_en, 0);
        end
        pump_tick = 1'b0;
        req[2] = 1'b0;
        cyc();
        do_txn(2, 2, 3, -1, 0, 1, 0);

        // Random contention, codes, targets, hang-ups and simultaneous tick/drop.
        for (int it = 0; it < 30; it++) begin
            mask = 4'($urandom_range(1, 15));
            w    = model_winner(mask);
            for (int n = 0; n < N; n++)
                if (mask[n]) begin
                    fuel[n*2 +: 2]     = 2'($urandom);
                    target[n*LW +: LW] = 8'($urandom);
                    req[n] = 1'b1;
                end
            f = $urandom_range(0, 3);
            t = $urandom_range(0, 30);
            d = (t > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, t - 1) : -1;
            do_txn(w, f, t, d, $urandom_range(0, 1), $urandom_range(0, 2), 0);
            req = '0;
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
